axi_slv_mem: RTL and testbench
==============================

// Module: axi_slv_mem
// PURPOSE
//   AXI slave-side responder backed by an internal word-addressed RAM. Terminates the slv_if
//   modport of axi_if: accepts AW/W, returns B; accepts AR, returns R bursts.
//   Serves as the default DUT/target model for master-driver and monitor bring-up.
//   Write and read paths are independent; each path holds one outstanding burst.
// PARAMETERS
//   ID_WIDTH    4     AxID/BID/RID width (matches `D_ID_WIDTH)
//   ADDR_WIDTH  32    byte address width (matches `D_ADDR_WIDTH)
//   DATA_WIDTH  32    data bus width, power of 2, >=8 (matches `D_DATA_WIDTH)
//   MEM_DEPTH   1024  RAM words of DATA_WIDTH bits
// PORTS
//   ACLK     in   1          clock, all logic on rising edge
//   ARESET   in   1          asynchronous reset, active-high
//   AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWPROT/AWVALID in  ID_W/ADDR_W/8/3/2/3/1  write addr
//   AWREADY  out  1          write address accept
//   WID/WDATA/WSTRB/WLAST/WVALID in  ID_W/DATA_W/DATA_W/8/1/1  write data (WID ignored)
//   WREADY   out  1          write data accept
//   BID/BRESP/BVALID out  ID_W/2/1  write response;  BREADY in 1
//   ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARPROT/ARVALID in  ID_W/ADDR_W/8/3/2/3/1  read addr
//   ARREADY  out  1          read address accept
//   RID/RDATA/RRESP/RLAST/RVALID out  ID_W/DATA_W/2/1/1  read data;  RREADY in 1
// BEHAVIOUR
//   Reset: every output 0; both FSMs to IDLE; RAM contents retained, not cleared.
//   Word index = addr[ADDR_WIDTH-1:log2(DATA_WIDTH/8)]; AxPROT ignored.
//   Beat address: FIXED(00) constant; INCR(01) += 1<<AxSIZE; WRAP(10) += 1<<AxSIZE,
//     wrapping within aligned block of (AxLEN+1)<<AxSIZE bytes.
//   Burst error (SLVERR=2'b10, whole burst): AxBURST=11; WRAP with AxLEN not 1/3/7/15;
//     AxSIZE > log2(DATA_WIDTH/8); any beat word index >= MEM_DEPTH (that beat only).
//   Errored write beats never modify RAM; errored read beats return RDATA=0.
//   Write FSM: W_IDLE (AWREADY=1) -AWVALID-> latch ID/addr/len/size/burst, beat cnt=0 ->
//     W_DATA (WREADY=1): each WVALID beat writes bytes enabled by WSTRB, cnt++;
//     beat cnt==AWLEN -> W_RESP. WLAST != (cnt==AWLEN) on any beat -> SLVERR, burst
//     still ends on cnt==AWLEN. W_RESP: BVALID=1, BID=latched AWID, BRESP=OKAY/SLVERR;
//     held stable until BREADY; then W_IDLE (AWREADY=1 next cycle).
//   Read FSM: R_IDLE (ARREADY=1) -ARVALID-> latch, R_DATA. RVALID=1 the cycle after AR
//     handshake with beat 0. Beat n held stable until RREADY; beat n+1 presented next
//     cycle (back-to-back, no bubble). RLAST=1 only on beat ARLEN. RID=latched ARID.
//     Last beat accepted -> R_IDLE (ARREADY=1 next cycle).
//   Read data is registered from RAM when a beat is loaded; same-cycle write to that
//     word -> read returns old data. Read full word regardless of AxSIZE.
//   Write and read FSMs run concurrently with no ordering between them.
//   ARESET asserted mid-burst: outputs drop to 0 immediately; partial write beats
//     already committed stay in RAM; no B/R issued for aborted bursts.
//   No AWVALID/WVALID ordering check: W beats before AW are simply not accepted.
// TESTING
//   Single write AW=0x10,LEN=0,SIZE=2,INCR,WDATA=0xDEADBEEF,WSTRB=F,AWID=3 -> BID=3
//     BRESP=00; read AR=0x10 LEN=0 -> RDATA=0xDEADBEEF RLAST=1 RRESP=00.
//   INCR LEN=3 @0x20 data 1..4, WSTRB=0x3 on beat 2 -> read back 1,2,(old&FFFF0000)|3,4;
//     RREADY toggled every other cycle -> RDATA/RLAST stable while stalled.
//   WRAP LEN=3 SIZE=2 @0x38 -> beats hit 0x38,0x3C,0x30,0x34; WRAP LEN=2 -> SLVERR.
//   Address word 1023 INCR LEN=1 -> beat0 OKAY data, beat1 SLVERR RDATA=0; write same
//     -> BRESP=SLVERR, RAM word 1023 updated, nothing wraps to word 0.
//   WLAST on beat 1 of LEN=3 -> 4 beats accepted, BRESP=SLVERR; BREADY held low 10
//     cycles -> BVALID/BID/BRESP stable, AWREADY=0 throughout.
//   ARESET pulsed during read beat 2 of LEN=7 -> all outputs 0 same cycle, ARREADY=1
//     first edge after release, new read returns correct data.

Source files
------------

// File: rtl/axi_slv_mem.sv
// axi_slv_mem
//   AXI slave responder backed by an internal word-addressed RAM. The write path
//   (AW/W/B) and the read path (AR/R) are independent state machines. Each path
//   holds one outstanding burst. FIXED, INCR and WRAP bursts are supported.
//   Illegal bursts and beats that fall outside the RAM answer SLVERR. An errored
//   write beat never touches the RAM, and an errored read beat returns zero data.
//
// Ports
//   ACLK, ARESET                         clock (rising edge), async active-high reset
//   AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWPROT/AWVALID -> AWREADY   write address
//   WID/WDATA/WSTRB/WLAST/WVALID -> WREADY                        write data (WID unused)
//   BID/BRESP/BVALID <- BREADY                                    write response
//   ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARPROT/ARVALID -> ARREADY   read address
//   RID/RDATA/RRESP/RLAST/RVALID <- RREADY                        read data
module axi_slv_mem #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [ID_WIDTH-1:0]     AWID,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic [7:0]              AWLEN,
  input  logic [2:0]              AWSIZE,
  input  logic [1:0]              AWBURST,
  input  logic [2:0]              AWPROT,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [ID_WIDTH-1:0]     WID,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WLAST,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [ID_WIDTH-1:0]     BID,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [ID_WIDTH-1:0]     ARID,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic [7:0]              ARLEN,
  input  logic [2:0]              ARSIZE,
  input  logic [1:0]              ARBURST,
  input  logic [2:0]              ARPROT,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [ID_WIDTH-1:0]     RID,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RLAST,
  output logic                    RVALID,
  input  logic                    RREADY
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_WIDTH - LSB;
  localparam int MEM_AW = $clog2(MEM_DEPTH);
  localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(MEM_DEPTH);
  localparam logic [2:0] MAX_SIZE = 3'(LSB);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wState_t;
  typedef enum logic       {R_IDLE, R_DATA}         rState_t;

  wState_t r_wState, w_wNext;
  rState_t r_rState, w_rNext;

  // A burst is illegal as a whole for a reserved burst type, an unsupported
  // wrap length, or a beat size wider than the data bus.
  function automatic logic burstBad(input logic [7:0] len, input logic [2:0] size,
                                    input logic [1:0] burst);
    logic bad;
    bad = 1'b0;
    if (burst == 2'b11) bad = 1'b1;
    if (burst == 2'b10 && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15))
      bad = 1'b1;
    if (size > MAX_SIZE) bad = 1'b1;
    return bad;
  endfunction

  // The WRAP boundary is the aligned block of (len+1)<<size bytes. The low bits
  // advance inside that block and the high bits stay fixed.
  function automatic logic [ADDR_WIDTH-1:0] nextAddr(input logic [ADDR_WIDTH-1:0] addr,
                                                     input logic [7:0] len,
                                                     input logic [2:0] size,
                                                     input logic [1:0] burst);
    logic [ADDR_WIDTH-1:0] step, sum, wrapMask, res;
    step     = ADDR_WIDTH'(1) << size;
    sum      = addr + step;
    wrapMask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    case (burst)
      2'b00:   res = addr;
      2'b10:   res = (addr & ~wrapMask) | (sum & wrapMask);
      default: res = sum;
    endcase
    return res;
  endfunction

  logic w_unused;
  assign w_unused = ^{AWPROT, ARPROT, WID};

  // r_live holds the ready outputs low while reset is active. They rise on the
  // first clock edge after reset is released.
  logic r_live;
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) r_live <= 1'b0;
    else        r_live <= 1'b1;
  end

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  // ---------------- write path ----------------
  logic [ID_WIDTH-1:0]   r_awId;
  logic [ADDR_WIDTH-1:0] r_wAddr;
  logic [7:0]            r_awLen, r_wCnt;
  logic [2:0]            r_awSize;
  logic [1:0]            r_awBurst;
  logic                  r_wBurstErr, r_wErr;

  logic              w_awHs, w_wBeat, w_wLastCnt, w_wInRange, w_wCommit, w_wBeatErr;
  logic [IDX_W-1:0]  w_wIdx;
  logic [MEM_AW-1:0] w_wMemIdx;

  assign w_awHs     = (r_wState == W_IDLE) && AWVALID && r_live;
  assign w_wBeat    = (r_wState == W_DATA) && WVALID;
  assign w_wLastCnt = (r_wCnt == r_awLen);
  assign w_wIdx     = r_wAddr[ADDR_WIDTH-1:LSB];
  assign w_wMemIdx  = w_wIdx[MEM_AW-1:0];
  assign w_wInRange = (w_wIdx < DEPTH_IDX);
  assign w_wCommit  = w_wBeat && !r_wBurstErr && w_wInRange;
  // A WLAST that disagrees with the beat count flags the response. The burst
  // still ends when the count reaches AWLEN.
  assign w_wBeatErr = !w_wInRange || (WLAST != w_wLastCnt);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) r_wState <= W_IDLE;
    else        r_wState <= w_wNext;
  end

  always_comb begin
    w_wNext = r_wState;
    AWREADY = 1'b0;
    WREADY  = 1'b0;
    BVALID  = 1'b0;
    case (r_wState)
      W_IDLE: begin
        AWREADY = r_live;
        if (w_awHs) w_wNext = W_DATA;
      end
      W_DATA: begin
        WREADY = 1'b1;
        if (WVALID && w_wLastCnt) w_wNext = W_RESP;
      end
      W_RESP: begin
        BVALID = 1'b1;
        if (BREADY) w_wNext = W_IDLE;
      end
      default: w_wNext = W_IDLE;
    endcase
  end

  // The burst attributes are latched on the AW handshake. r_wAddr always holds
  // the address of the beat that is accepted next. r_wErr is sticky, so any
  // bad beat turns the whole response into SLVERR.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_awId      <= '0;
      r_wAddr     <= '0;
      r_awLen     <= '0;
      r_awSize    <= '0;
      r_awBurst   <= '0;
      r_wCnt      <= '0;
      r_wBurstErr <= 1'b0;
      r_wErr      <= 1'b0;
    end else if (w_awHs) begin
      r_awId      <= AWID;
      r_wAddr     <= AWADDR;
      r_awLen     <= AWLEN;
      r_awSize    <= AWSIZE;
      r_awBurst   <= AWBURST;
      r_wCnt      <= '0;
      r_wBurstErr <= burstBad(AWLEN, AWSIZE, AWBURST);
      r_wErr      <= burstBad(AWLEN, AWSIZE, AWBURST);
    end else if (w_wBeat) begin
      r_wCnt  <= r_wCnt + 8'd1;
      r_wAddr <= nextAddr(r_wAddr, r_awLen, r_awSize, r_awBurst);
      if (w_wBeatErr) r_wErr <= 1'b1;
    end
  end

  assign BID   = r_awId;
  assign BRESP = r_wErr ? RESP_SLVERR : RESP_OKAY;

  // The RAM has no reset, so its contents survive ARESET. A byte lane is
  // written only when its WSTRB bit is set.
  always_ff @(posedge ACLK) begin
    if (w_wCommit) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (WSTRB[b]) r_mem[w_wMemIdx][b*8 +: 8] <= WDATA[b*8 +: 8];
      end
    end
  end

  // ---------------- read path ----------------
  logic [ID_WIDTH-1:0]   r_arId;
  logic [ADDR_WIDTH-1:0] r_rAddr;
  logic [7:0]            r_arLen, r_rCnt;
  logic [2:0]            r_arSize;
  logic [1:0]            r_arBurst;
  logic                  r_rBurstErr;
  logic [DATA_WIDTH-1:0] r_rData;
  logic [1:0]            r_rResp;
  logic                  r_rLast;

  logic                  w_rLoadFirst, w_rAdvance, w_rDone;
  logic [ADDR_WIDTH-1:0] w_rBeatAddr;
  logic [7:0]            w_rLen;
  logic [2:0]            w_rSize;
  logic [1:0]            w_rBurst;
  logic                  w_rBeatBad, w_rInRange, w_rBeatErr;
  logic [IDX_W-1:0]      w_rIdx;
  logic [MEM_AW-1:0]     w_rMemIdx;

  assign w_rLoadFirst = (r_rState == R_IDLE) && ARVALID && r_live;
  assign w_rAdvance   = (r_rState == R_DATA) && RREADY && !r_rLast;
  assign w_rDone      = (r_rState == R_DATA) && RREADY && r_rLast;

  // Beat 0 is loaded straight from the AR channel. Later beats come from the
  // latched copy.
  always_comb begin
    if (r_rState == R_IDLE) begin
      w_rBeatAddr = ARADDR;
      w_rLen      = ARLEN;
      w_rSize     = ARSIZE;
      w_rBurst    = ARBURST;
      w_rBeatBad  = burstBad(ARLEN, ARSIZE, ARBURST);
    end else begin
      w_rBeatAddr = r_rAddr;
      w_rLen      = r_arLen;
      w_rSize     = r_arSize;
      w_rBurst    = r_arBurst;
      w_rBeatBad  = r_rBurstErr;
    end
  end

  assign w_rIdx     = w_rBeatAddr[ADDR_WIDTH-1:LSB];
  assign w_rMemIdx  = w_rIdx[MEM_AW-1:0];
  assign w_rInRange = (w_rIdx < DEPTH_IDX);
  assign w_rBeatErr = w_rBeatBad || !w_rInRange;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) r_rState <= R_IDLE;
    else        r_rState <= w_rNext;
  end

  always_comb begin
    w_rNext = r_rState;
    ARREADY = 1'b0;
    RVALID  = 1'b0;
    case (r_rState)
      R_IDLE: begin
        ARREADY = r_live;
        if (w_rLoadFirst) w_rNext = R_DATA;
      end
      R_DATA: begin
        RVALID = 1'b1;
        if (w_rDone) w_rNext = R_IDLE;
      end
      default: w_rNext = R_IDLE;
    endcase
  end

  // The RAM word is captured into r_rData when a beat is loaded. A write to the
  // same word in that cycle is therefore not seen until a later read. The beat
  // registers change only on a load, so a stalled beat stays stable.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_arId      <= '0;
      r_rAddr     <= '0;
      r_arLen     <= '0;
      r_arSize    <= '0;
      r_arBurst   <= '0;
      r_rCnt      <= '0;
      r_rBurstErr <= 1'b0;
      r_rData     <= '0;
      r_rResp     <= '0;
      r_rLast     <= 1'b0;
    end else begin
      if (w_rLoadFirst) begin
        r_arId      <= ARID;
        r_arLen     <= ARLEN;
        r_arSize    <= ARSIZE;
        r_arBurst   <= ARBURST;
        r_rCnt      <= '0;
        r_rBurstErr <= w_rBeatBad;
      end else if (w_rAdvance) begin
        r_rCnt <= r_rCnt + 8'd1;
      end
      if (w_rLoadFirst || w_rAdvance) begin
        r_rAddr <= nextAddr(w_rBeatAddr, w_rLen, w_rSize, w_rBurst);
        r_rData <= w_rBeatErr ? '0 : r_mem[w_rMemIdx];
        r_rResp <= w_rBeatErr ? RESP_SLVERR : RESP_OKAY;
        r_rLast <= w_rLoadFirst ? (ARLEN == 8'd0) : ((r_rCnt + 8'd1) == r_arLen);
      end else if (w_rDone) begin
        r_rLast <= 1'b0;
      end
    end
  end

  assign RID   = r_arId;
  assign RDATA = r_rData;
  assign RRESP = r_rResp;
  assign RLAST = r_rLast;

endmodule

// File: tb/tb_axi_slv_mem.sv
// tb_axi_slv_mem
//   Directed bench for axi_slv_mem. A table of single-beat write/read-back
//   vectors is applied first. Hand-written sequences then cover multi-beat
//   bursts, strobes, wrap order, RAM-end errors, WLAST misuse with B
//   backpressure, and reset in the middle of a burst.
module tb_axi_slv_mem;

  logic        ACLK, ARESET;
  logic [3:0]  AWID;
  logic [31:0] AWADDR;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic [2:0]  AWPROT;
  logic        AWVALID, AWREADY;
  logic [3:0]  WID;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST, WVALID, WREADY;
  logic [3:0]  BID;
  logic [1:0]  BRESP;
  logic        BVALID, BREADY;
  logic [3:0]  ARID;
  logic [31:0] ARADDR;
  logic [7:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic [2:0]  ARPROT;
  logic        ARVALID, ARREADY;
  logic [3:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST, RVALID, RREADY;

  axi_slv_mem #(.ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(1024)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int total = 0;
  int bad   = 0;

  logic [49:0] allOuts;
  assign allOuts = {AWREADY, WREADY, BID, BRESP, BVALID, ARREADY,
                    RID, RDATA, RRESP, RLAST, RVALID};

  logic [31:0] wData   [16];
  logic [3:0]  wStrb   [16];
  logic [31:0] expData [16];
  logic [1:0]  expResp [16];

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  expBresp;
    logic [31:0] expRdata;
    logic [1:0]  expRresp;
  } vec_t;

  vec_t vecs [9];

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h want=%h", name, got, exp);
    end
  endtask

  task automatic timeoutFail(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s timed out waiting for handshake", name);
  endtask

  // Write burst from wData/wStrb. WLAST is driven on beat lastBeat. BREADY is
  // held low for bDelay cycles once BVALID appears.
  task automatic applyStimulus(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                               input logic [2:0] size, input logic [1:0] burst, input int lastBeat,
                               input int bDelay, input logic [1:0] expB);
    int guard;
    AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
    guard = 0;
    while (!AWREADY && guard < 50) begin @(posedge ACLK); #1; guard++; end
    if (!AWREADY) timeoutFail("awHandshake");
    @(posedge ACLK); #1;
    AWVALID = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      WDATA = wData[b]; WSTRB = wStrb[b]; WLAST = (b == lastBeat); WVALID = 1'b1;
      guard = 0;
      while (!WREADY && guard < 50) begin @(posedge ACLK); #1; guard++; end
      if (!WREADY) timeoutFail("wHandshake");
      @(posedge ACLK); #1;
    end
    WVALID = 1'b0; WLAST = 1'b0;
    guard = 0;
    while (!BVALID && guard < 50) begin @(posedge ACLK); #1; guard++; end
    checkOutput("bValid", BVALID, 1);
    checkOutput("bId", BID, id);
    checkOutput("bResp", BRESP, expB);
    for (int i = 0; i < bDelay; i++) begin
      @(posedge ACLK); #1;
      checkOutput("bHoldStable", {BVALID, BID, BRESP, AWREADY}, {1'b1, id, expB, 1'b0});
    end
    BREADY = 1'b1;
    @(posedge ACLK); #1;
    BREADY = 1'b0;
    checkOutput("bDoneAwReady", {BVALID, AWREADY}, 2'b01);
  endtask

  // Read burst checked beat by beat against expData/expResp. With stall set,
  // RREADY is low for one cycle before each beat is accepted.
  task automatic doRead(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                        input logic [2:0] size, input logic [1:0] burst, input bit stall);
    int guard;
    ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
    guard = 0;
    while (!ARREADY && guard < 50) begin @(posedge ACLK); #1; guard++; end
    if (!ARREADY) timeoutFail("arHandshake");
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      if (stall) begin
        RREADY = 1'b0;
        @(posedge ACLK); #1;
        checkOutput("rStallHold", {RVALID, RID, RDATA, RRESP, RLAST},
                    {1'b1, id, expData[b], expResp[b], (b == int'(len))});
      end
      checkOutput("rValid", RVALID, 1);
      checkOutput("rId", RID, id);
      checkOutput("rData", RDATA, expData[b]);
      checkOutput("rResp", RRESP, expResp[b]);
      checkOutput("rLast", RLAST, (b == int'(len)));
      RREADY = 1'b1;
      @(posedge ACLK); #1;
    end
    RREADY = 1'b0;
    checkOutput("rDoneArReady", {RVALID, ARREADY}, 2'b01);
  endtask

  // Watchdog so the run always ends even if the DUT wedges.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0] = '{4'h3, 32'h10,   3'd2, 2'b01, 32'hDEADBEEF, 4'hF, 2'b00, 32'hDEADBEEF, 2'b00};
    vecs[1] = '{4'h5, 32'h14,   3'd2, 2'b00, 32'h01234567, 4'hF, 2'b00, 32'h01234567, 2'b00};
    vecs[2] = '{4'h7, 32'h18,   3'd3, 2'b01, 32'h55555555, 4'hF, 2'b10, 32'h0,        2'b10};
    vecs[3] = '{4'h1, 32'h1C,   3'd2, 2'b11, 32'h66666666, 4'hF, 2'b10, 32'h0,        2'b10};
    vecs[4] = '{4'hF, 32'h1000, 3'd2, 2'b01, 32'h77777777, 4'hF, 2'b10, 32'h0,        2'b10};
    vecs[5] = '{4'h2, 32'h24,   3'd2, 2'b01, 32'h11223344, 4'hF, 2'b00, 32'h11223344, 2'b00};
    vecs[6] = '{4'h2, 32'h24,   3'd0, 2'b01, 32'hAABBCCDD, 4'h1, 2'b00, 32'h112233DD, 2'b00};
    vecs[7] = '{4'h9, 32'h28,   3'd2, 2'b01, 32'h12345678, 4'hF, 2'b00, 32'h12345678, 2'b00};
    vecs[8] = '{4'h4, 32'h2C,   3'd2, 2'b10, 32'h88888888, 4'hF, 2'b10, 32'h0,        2'b10};

    ARESET = 1'b1;
    AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWPROT = '0; AWVALID = 1'b0;
    WID = '0; WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARPROT = '0; ARVALID = 1'b0;
    RREADY = 1'b0;

    #2;
    checkOutput("resetOutsZero", allOuts, 0);
    @(posedge ACLK); @(posedge ACLK); #2;
    ARESET = 1'b0;
    checkOutput("readyBeforeEdge", {AWREADY, ARREADY}, 2'b00);
    @(posedge ACLK); #1;
    checkOutput("readyAfterRelease", {AWREADY, ARREADY}, 2'b11);

    $display("[TB] single-beat vector table");
    for (int v = 0; v < 9; v++) begin
      wData[0] = vecs[v].data;
      wStrb[0] = vecs[v].strb;
      applyStimulus(vecs[v].id, vecs[v].addr, 8'd0, vecs[v].size, vecs[v].burst, 0, 0, vecs[v].expBresp);
      expData[0] = vecs[v].expRdata;
      expResp[0] = vecs[v].expRresp;
      doRead(vecs[v].id, vecs[v].addr, 8'd0, vecs[v].size, vecs[v].burst, 1'b0);
    end

    $display("[TB] INCR burst with partial strobe and stalled read");
    wData[0] = 32'd1; wData[1] = 32'd2; wData[2] = 32'd3; wData[3] = 32'd4;
    wStrb[0] = 4'hF;  wStrb[1] = 4'hF;  wStrb[2] = 4'h3;  wStrb[3] = 4'hF;
    applyStimulus(4'h6, 32'h20, 8'd3, 3'd2, 2'b01, 3, 0, 2'b00);
    expData[0] = 32'd1; expData[1] = 32'd2; expData[2] = 32'h12340003; expData[3] = 32'd4;
    for (int i = 0; i < 4; i++) expResp[i] = 2'b00;
    doRead(4'h6, 32'h20, 8'd3, 3'd2, 2'b01, 1'b1);

    $display("[TB] WRAP ordering and illegal WRAP length");
    wData[0] = 32'h100; wData[1] = 32'h101; wData[2] = 32'h102; wData[3] = 32'h103;
    for (int i = 0; i < 4; i++) wStrb[i] = 4'hF;
    applyStimulus(4'hA, 32'h38, 8'd3, 3'd2, 2'b10, 3, 0, 2'b00);
    expData[0] = 32'h102; doRead(4'hA, 32'h30, 8'd0, 3'd2, 2'b01, 1'b0);
    expData[0] = 32'h103; doRead(4'hA, 32'h34, 8'd0, 3'd2, 2'b01, 1'b0);
    expData[0] = 32'h100; doRead(4'hA, 32'h38, 8'd0, 3'd2, 2'b01, 1'b0);
    expData[0] = 32'h101; doRead(4'hA, 32'h3C, 8'd0, 3'd2, 2'b01, 1'b0);
    expData[0] = 32'h100; expData[1] = 32'h101; expData[2] = 32'h102; expData[3] = 32'h103;
    doRead(4'hB, 32'h38, 8'd3, 3'd2, 2'b10, 1'b0);
    wData[0] = 32'hBAD0; wData[1] = 32'hBAD1; wData[2] = 32'hBAD2;
    applyStimulus(4'hC, 32'h30, 8'd2, 3'd2, 2'b10, 2, 0, 2'b10);
    for (int i = 0; i < 3; i++) begin expData[i] = 32'h0; expResp[i] = 2'b10; end
    doRead(4'hC, 32'h30, 8'd2, 3'd2, 2'b10, 1'b0);
    expData[0] = 32'h102; expResp[0] = 2'b00;
    doRead(4'hC, 32'h30, 8'd0, 3'd2, 2'b01, 1'b0);

    $display("[TB] end of RAM");
    wData[0] = 32'h0BADF00D; wStrb[0] = 4'hF;
    applyStimulus(4'h1, 32'h0, 8'd0, 3'd2, 2'b01, 0, 0, 2'b00);
    wData[0] = 32'hCAFE0001; wData[1] = 32'hCAFE0002; wStrb[1] = 4'hF;
    applyStimulus(4'h2, 32'hFFC, 8'd1, 3'd2, 2'b01, 1, 0, 2'b10);
    expData[0] = 32'hCAFE0001; expResp[0] = 2'b00;
    expData[1] = 32'h0;        expResp[1] = 2'b10;
    doRead(4'h3, 32'hFFC, 8'd1, 3'd2, 2'b01, 1'b0);
    expData[0] = 32'h0BADF00D; expResp[0] = 2'b00;
    doRead(4'h3, 32'h0, 8'd0, 3'd2, 2'b01, 1'b0);

    $display("[TB] early WLAST with B backpressure");
    for (int i = 0; i < 4; i++) begin wData[i] = 32'h500 + i; wStrb[i] = 4'hF; end
    applyStimulus(4'hD, 32'h40, 8'd3, 3'd2, 2'b01, 1, 10, 2'b10);

    $display("[TB] reset during read beat 2");
    ARID = 4'h8; ARADDR = 32'h20; ARLEN = 8'd7; ARSIZE = 3'd2; ARBURST = 2'b01; ARVALID = 1'b1;
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
    checkOutput("rstBeat0Valid", RVALID, 1);
    RREADY = 1'b1;
    @(posedge ACLK); #1;
    @(posedge ACLK); #1;
    RREADY = 1'b0;
    checkOutput("rstBeat2Data", {RVALID, RDATA, RLAST}, {1'b1, 32'h12340003, 1'b0});
    ARESET = 1'b1;
    #1;
    checkOutput("rstMidBurstZero", allOuts, 0);
    @(posedge ACLK); #2;
    ARESET = 1'b0;
    checkOutput("rstReadyLowBeforeEdge", ARREADY, 0);
    @(posedge ACLK); #1;
    checkOutput("rstArReadyAfterRelease", {ARREADY, RVALID, BVALID}, 3'b100);
    expData[0] = 32'hDEADBEEF; expResp[0] = 2'b00;
    doRead(4'h9, 32'h10, 8'd0, 3'd2, 2'b01, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
